// File: rtl/line_mem_responder_if.sv
// Cache-to-memory line request bus between the L1 data cache controller
// (master) and the line memory responder (slave). Signal names are given
// from the responder's point of view.
interface line_mem_responder_if #(
   parameter int DATA_WIDTH = 256,
   parameter int ADDR_WIDTH = 32
);

   logic [ADDR_WIDTH-1:0] addr_i;
   logic [DATA_WIDTH-1:0] data_i;
   logic                  enable_i;
   logic                  write_i;
   logic                  ack_o;
   logic [DATA_WIDTH-1:0] data_o;
   logic                  busy_o;

   // Requester side: drives the request, watches for completion
   modport master (
      output addr_i,
      output data_i,
      output enable_i,
      output write_i,
      input  ack_o,
      input  data_o,
      input  busy_o
   );

   // Responder side: consumes the request, signals completion
   modport slave (
      input  addr_i,
      input  data_i,
      input  enable_i,
      input  write_i,
      output ack_o,
      output data_o,
      output busy_o
   );

endinterface

// File: rtl/line_mem_responder.sv
// Line memory responder: accepts one full-line read or write from the data
// cache, waits a fixed number of cycles to model memory access time, then
// pulses ack for one cycle with the line data. The line array itself is not
// reset, so its contents survive a reset of the control logic.
module line_mem_responder #(
   parameter int DATA_WIDTH = 256,
   parameter int ADDR_WIDTH = 32,
   parameter int DEPTH      = 512,
   parameter int LATENCY    = 10
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   line_mem_responder_if.slave   bus
);

   localparam int IDX_W = $clog2(DEPTH);

   // The counter only ever has to reach LATENCY-2, so size it for that.
   localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
   localparam int unsigned LAST_COUNT = (LATENCY >= 2) ? (LATENCY - 2) : 0;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST_COUNT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } state_e;

   state_e                state_q;
   logic [CNT_W-1:0]      count_q;
   logic [IDX_W-1:0]      idx_q;
   logic                  write_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  ack_q;
   logic                  busy_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [IDX_W-1:0]      reqIdx;
   logic                  enterAck_d;
   logic [IDX_W-1:0]      ackIdx_d;
   logic                  ackWrite_d;
   logic [DATA_WIDTH-1:0] ackData_d;
   logic [DATA_WIDTH-1:0] ackLine_d;
   logic                  memWe;
   logic                  unusedAddrBits;

   // Byte offset within the line and address bits above the index field do
   // not select anything; higher addresses alias modulo DEPTH lines.
   assign reqIdx         = bus.addr_i[5 +: IDX_W];
   assign unusedAddrBits = ^{bus.addr_i[4:0], bus.addr_i[ADDR_WIDTH-1:5+IDX_W]};

   // Decide whether the coming edge enters ACK and which line/data that
   // transfer uses. With LATENCY=1 the request goes straight from IDLE to
   // ACK, so the live inputs are used instead of the latched copies.
   always_comb begin
      enterAck_d = 1'b0;
      ackIdx_d   = idx_q;
      ackWrite_d = write_q;
      ackData_d  = wdata_q;
      case (state_q)
         IDLE: begin
            if (bus.enable_i && (LATENCY == 1)) begin
               enterAck_d = 1'b1;
               ackIdx_d   = reqIdx;
               ackWrite_d = bus.write_i;
               ackData_d  = bus.data_i;
            end
         end
         WAIT: begin
            if (count_q == LAST_CNT) begin
               enterAck_d = 1'b1;
            end
         end
         default: ;
      endcase
      ackLine_d = ackWrite_d ? ackData_d : mem_q[ackIdx_d];
      memWe     = enterAck_d && ackWrite_d && rst_i;
   end

   // Request sequencing: accept in IDLE, count out the latency in WAIT,
   // present the one-cycle ack in ACK; ack, busy and data are registered.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         count_q <= '0;
         idx_q   <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         ack_q   <= 1'b0;
         busy_q  <= 1'b0;
         data_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               ack_q <= 1'b0;
               if (bus.enable_i) begin
                  idx_q   <= reqIdx;
                  write_q <= bus.write_i;
                  wdata_q <= bus.data_i;
                  count_q <= '0;
                  busy_q  <= 1'b1;
                  if (enterAck_d) begin
                     state_q <= ACK;
                     ack_q   <= 1'b1;
                     data_q  <= ackLine_d;
                  end else begin
                     state_q <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (enterAck_d) begin
                  state_q <= ACK;
                  ack_q   <= 1'b1;
                  data_q  <= ackLine_d;
               end else begin
                  count_q <= count_q + 1'b1;
               end
            end
            ACK: begin
               state_q <= IDLE;
               ack_q   <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               ack_q   <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Line storage: written only on the edge that enters ACK for a write,
   // never cleared, and left untouched when reset cuts a write short.
   always_ff @(posedge clk_i) begin
      if (memWe) begin
         mem_q[ackIdx_d] <= ackData_d;
      end
   end

   assign bus.ack_o  = ack_q;
   assign bus.busy_o = busy_q;
   assign bus.data_o = data_q;

endmodule
